// File: rtl/gcd_job_feeder.sv
// gcd_job_feeder: accepts operand pairs, drives one job at a time through an
// external GCD core with a timeout watchdog, and presents each result record
// downstream with a valid/ready handshake.
module gcd_job_feeder #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        gcd_start,
    output logic [7:0]  gcd_a,
    output logic [7:0]  gcd_b,
    input  logic        gcd_done,
    input  logic [15:0] gcd_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_a,
    output logic [7:0]  out_b,
    output logic [7:0]  out_gcd,
    output logic        out_err,
    output logic [15:0] jobs_done,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RUN, WAIT_DONE, OUTPUT} state_t;

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    // the counter reaches TIMEOUT_CYCLES on the edge where this is true
    assign tmo_hit  = tmo_cnt == CW'(TIMEOUT_CYCLES - 1);
    // waiting for gcd_done also holds off new work after an aborted job
    assign in_ready = state == IDLE && gcd_done;
    assign busy     = state != IDLE;

    // job sequencer with registered core and record outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            gcd_start <= 1'b0;
            gcd_a     <= '0;
            gcd_b     <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_gcd   <= '0;
            out_err   <= 1'b0;
            jobs_done <= '0;
        end else begin
            jobs_done <= jobs_done + 16'(out_valid && out_ready);
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    gcd_a     <= in_a;
                    gcd_b     <= in_b;
                    out_a     <= in_a;
                    out_b     <= in_b;
                    tmo_cnt   <= '0;
                    gcd_start <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    gcd_start <= 1'b0;
                    state     <= WAIT_RUN;
                end
                WAIT_RUN: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (tmo_hit) begin
                        out_gcd   <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else if (!gcd_done) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    // a completion coinciding with the timeout still counts
                    if (gcd_done || tmo_hit) begin
                        out_gcd   <= gcd_done ? gcd_result[7:0] : 8'd0;
                        out_err   <= !gcd_done;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_job_feeder.sv
// tb_gcd_job_feeder: table-driven, directed and randomized checks of the job
// feeder against a behavioural GCD core and a scoreboard model.
module tb_gcd_job_feeder;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_ready, gcd_start, out_valid, out_err, busy;
    logic [7:0]  gcd_a, gcd_b, out_a, out_b, out_gcd;
    logic [15:0] jobs_done;

    logic        gcd_done = 1'b1;
    logic [15:0] gcd_result = '0;
    int          run_len = 1;
    bit          stuck = 1'b0;
    bit          core_busy = 1'b0;
    int          left = 0;
    logic [7:0]  ca = '0;
    logic [7:0]  cb = '0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic       e;
    } rec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        int         run;
    } vec_t;

    rec_t        sb[$];
    rec_t        r;
    logic        exp_e;
    int          model_jobs = 0;
    bit          in_job = 1'b0;
    bit          exp_start = 1'b0;
    bit          prev_hold = 1'b0;
    logic [24:0] prev_rec = '0;
    bit          rand_on = 1'b0;

    gcd_job_feeder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .gcd_start(gcd_start), .gcd_a(gcd_a),
        .gcd_b(gcd_b), .gcd_done(gcd_done), .gcd_result(gcd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .out_b(out_b), .out_gcd(out_gcd), .out_err(out_err),
        .jobs_done(jobs_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // behavioural GCD core: done drops on start and returns run_len edges later
    always @(posedge clk) begin
        if (gcd_start) begin
            core_busy <= 1'b1;
            gcd_done  <= 1'b0;
            left      <= run_len;
            ca        <= gcd_a;
            cb        <= gcd_b;
        end else if (core_busy && !stuck) begin
            if (left <= 1) begin
                core_busy  <= 1'b0;
                gcd_done   <= 1'b1;
                gcd_result <= {8'($urandom), gcd8(ca, cb)};
            end else begin
                left <= left - 1;
            end
        end
    end

    // scoreboard and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            in_job     = 1'b0;
            exp_start  = 1'b0;
            model_jobs = 0;
            prev_hold  = 1'b0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(!in_job && gcd_done));
            check("busy", 64'(busy), 64'(in_job));
            check("gcd_start", 64'(gcd_start), 64'(exp_start));
            exp_start = 1'b0;
            if (!in_job) check("idle_no_valid", 64'(out_valid), 64'(0));
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_record", 64'({out_a, out_b, out_gcd, out_err}), 64'(prev_rec));
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    r = sb.pop_front();
                    check("record", 64'({out_a, out_b, out_gcd, out_err}), 64'(r));
                end
                model_jobs++;
                in_job = 1'b0;
            end
            prev_hold = out_valid && !out_ready;
            prev_rec  = {out_a, out_b, out_gcd, out_err};
            if (in_valid && in_ready) begin
                exp_e = stuck || run_len >= TMO;
                sb.push_back('{in_a, in_b, exp_e ? 8'd0 : gcd8(in_a, in_b), exp_e});
                in_job    = 1'b1;
                exp_start = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // offer one pair, return at the first negedge with out_valid high
    task automatic send(input logic [7:0] a, input logic [7:0] b, output int lat);
        int n = 0;
        tick();
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accepted", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", 64'(out_valid), 64'(1));
    endtask

    initial begin
        vec_t tbl[9];
        int   lat, n;
        bit   seen;

        tbl = '{'{8'd12, 8'd18, 8'd6, 1}, '{8'd0, 8'd0, 8'd0, 1}, '{8'd17, 8'd5, 8'd1, 2},
                '{8'd255, 8'd85, 8'd85, 3}, '{8'd7, 8'd0, 8'd7, 1}, '{8'd0, 8'd9, 8'd9, 2},
                '{8'd1, 8'd1, 8'd1, 1}, '{8'd200, 8'd150, 8'd50, 5}, '{8'd128, 8'd96, 8'd32, 4}};

        @(negedge clk);
        check("reset_outputs", 64'({gcd_start, gcd_a, gcd_b, out_valid, out_a, out_b,
                                    out_gcd, out_err, jobs_done, busy}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_len = tbl[i].run;
            send(tbl[i].a, tbl[i].b, lat);
            check("table_record", 64'({out_a, out_b, out_gcd, out_err}),
                  64'({tbl[i].a, tbl[i].b, tbl[i].g, 1'b0}));
            check("table_latency", 64'(lat), 64'(tbl[i].run + 3));
            tick();
            if (i == 0) check("jobs_after_first", 64'(jobs_done), 64'(1));
        end
        check("jobs_after_table", 64'(jobs_done), 64'(9));

        out_ready = 1'b0;
        run_len = 2;
        send(8'd48, 8'd36, lat);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_record", 64'({out_a, out_b, out_gcd, out_err}), 64'({8'd48, 8'd36, 8'd12, 1'b0}));
            check("stall_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        tick();

        run_len = TMO - 1;
        send(8'd40, 8'd24, lat);
        check("race_record", 64'({out_a, out_b, out_gcd, out_err}), 64'({8'd40, 8'd24, 8'd8, 1'b0}));
        check("race_latency", 64'(lat), 64'(66));
        run_len = TMO;
        send(8'd40, 8'd24, lat);
        check("late_record", 64'({out_a, out_b, out_gcd, out_err}), 64'({8'd40, 8'd24, 8'd0, 1'b1}));
        check("late_latency", 64'(lat), 64'(66));
        tick();

        stuck = 1'b1;
        run_len = 5;
        send(8'd30, 8'd20, lat);
        check("stuck_record", 64'({out_a, out_b, out_gcd, out_err}), 64'({8'd30, 8'd20, 8'd0, 1'b1}));
        check("stuck_latency", 64'(lat), 64'(66));
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stuck_in_ready", 64'(in_ready), 64'(0));
        end
        stuck = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_core", 64'(in_ready), 64'(1));

        run_len = 10;
        tick();
        in_a = 8'd100;
        in_b = 8'd75;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tick();
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("in_wait_done", 64'({busy, gcd_done}), 64'({1'b1, 1'b0}));
        #2 reset = 1'b1;
        #1 check("async_reset", 64'({gcd_start, gcd_a, gcd_b, out_valid, out_a, out_b,
                                    out_gcd, out_err, jobs_done, busy}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("no_record_after_reset", 64'(seen), 64'(0));
        run_len = 1;
        send(8'd9, 8'd6, lat);
        check("post_reset_record", 64'({out_a, out_b, out_gcd, out_err}), 64'({8'd9, 8'd6, 8'd3, 1'b0}));
        tick();
        check("post_reset_jobs", 64'(jobs_done), 64'(1));

        @(negedge clk);
        force dut.jobs_done = 16'hFFFF;
        tick();
        release dut.jobs_done;
        model_jobs = 65535;
        @(negedge clk);
        check("preload", 64'(jobs_done), 64'(16'hFFFF));
        send(8'd21, 8'd14, lat);
        check("wrap_record", 64'({out_a, out_b, out_gcd, out_err}), 64'({8'd21, 8'd14, 8'd7, 1'b0}));
        tick();
        check("jobs_wrap", 64'(jobs_done), 64'(0));

        rand_on = 1'b1;
        fork
            while (rand_on) begin
                @(posedge clk);
                #1 if (rand_on) out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            run_len = $urandom_range(1, 8);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
                 ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom), lat);
        end
        rand_on = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tick();
        check("sb_drained", 64'(sb.size()), 64'(0));
        @(negedge clk);
        check("jobs_model", 64'(jobs_done), 64'(16'(model_jobs)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gcd_job_feeder.md
GCD_JOB_FEEDER -- requirements
Module: gcd_job_feeder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum cycles from gcd_start to captured result before the job is aborted.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  upstream operand pair valid.
REQ-005 in_ready  out  1  feeder accepts a pair this cycle.
REQ-006 in_a, in_b  in  8 each  operand pair.
REQ-007 gcd_start  out  1  start pulse to the GCD core.
REQ-008 gcd_a, gcd_b  out  8 each  registered operands to the GCD core.
REQ-009 gcd_done  in  1  GCD core done; high in its idle and finished states, low while running.
REQ-010 gcd_result  in  16  GCD core result; only bits [7:0] are used.
REQ-011 out_valid  out  1  result record valid.
REQ-012 out_ready  in  1  downstream accepts the record.
REQ-013 out_a, out_b  out  8 each  operands of the reported job.
REQ-014 out_gcd  out  8  GCD of out_a and out_b.
REQ-015 out_err  out  1  job aborted by timeout; out_gcd is then 0.
REQ-016 jobs_done  out  16  count of records accepted downstream.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 States: IDLE, ISSUE, WAIT_RUN, WAIT_DONE, OUTPUT.
REQ-019 in_ready is 1 only when state is IDLE and gcd_done is 1.
REQ-020 On in_valid && in_ready: latch in_a/in_b into gcd_a/gcd_b and out_a/out_b, clear the timeout counter, and go to ISSUE.
REQ-021 ISSUE lasts exactly 1 cycle with gcd_start=1, then goes to WAIT_RUN; gcd_start is 0 in every other state.
REQ-022 WAIT_RUN: wait for gcd_done==0, then go to WAIT_DONE.
REQ-023 WAIT_DONE: on gcd_done==1, capture gcd_result[7:0] into out_gcd, set out_err=0, and go to OUTPUT.
REQ-024 The timeout counter increments every cycle in WAIT_RUN and WAIT_DONE.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES: go to OUTPUT with out_err=1 and out_gcd=0.
REQ-026 A real completion in the same cycle as the timeout wins: the result is captured and out_err=0.
REQ-027 OUTPUT: out_valid=1 with out_a/out_b/out_gcd/out_err held stable until out_ready; on the handshake go to IDLE.
REQ-028 out_valid is 0 in all other states.
REQ-029 Minimum job latency is 4 cycles from the input handshake to out_valid, given a 1-cycle GCD run.
REQ-030 jobs_done increments by 1 on each out_valid && out_ready, and wraps from 16'hFFFF to 0.
REQ-031 A new input is not accepted in the same cycle as an output handshake; the earliest next acceptance is the following cycle.
REQ-032 After a timeout, no new job is issued until gcd_done returns to 1 (enforced by REQ-019).
REQ-033 Operands of 0 are passed through unmodified; the GCD core defines the result (gcd(0,0)=0, gcd(a,0)=a).

Reset
REQ-034 While reset is high: state=IDLE and the timeout counter is 0.
REQ-035 While reset is high: gcd_start=0, gcd_a=gcd_b=0, out_valid=0, out_a=out_b=out_gcd=0, out_err=0, jobs_done=0, busy=0.
REQ-036 Reset asserted mid-job discards the job with no output record; after deassertion, jobs are accepted once gcd_done==1.

Verification
REQ-037 Feed (12,18) with out_ready=1 against the real GCD core -> exactly one record out_gcd=6, out_err=0, jobs_done=1, and a single-cycle gcd_start.
REQ-038 Back-to-back jobs (0,0), (17,5), (255,85) -> records 0, 1, 85 in order; jobs_done=3; in_ready low throughout each job.
REQ-039 Hold out_ready=0 for 10 cycles during job (48,36) -> out_valid and record (48,36,12) stable for all 10 cycles; in_ready=0 throughout.
REQ-040 Stub core with gcd_done stuck at 0 after start, TIMEOUT_CYCLES=64 -> record out_err=1, out_gcd=0 on the 65th cycle after ISSUE; in_ready stays 0 until the stub raises gcd_done.
REQ-041 Assert reset in WAIT_DONE of job (100,75) -> all outputs return to reset values asynchronously; no record emitted; next job (9,6) -> out_gcd=3.
REQ-042 Preload jobs_done to 16'hFFFF via a forced run, complete 1 job -> jobs_done=0.
